// File: rtl/macro_credit_cnt3.sv
// macro_credit_cnt3 -- 3-bit credit counter for small buffers (7 entries or fewer).
//
// Gates a consumer valid/ready handshake on available credits. Credits are
// counted back in from a downstream return pulse. A drain request blocks new
// consumes until every outstanding credit has come back.
//
// Ports:
//   clk              rising-edge clock
//   resetn           asynchronous active-low reset, synchronous release
//   i_consume_valid  requester wants one credit
//   o_consume_ready  credit grantable this cycle (registers only)
//   i_return         one credit returned (at most one per cycle)
//   i_drain          drain request pulse
//   i_err_clear      clears the sticky error flags
//   o_credits        current credit count
//   o_empty          o_credits == 0
//   o_full           o_credits == MAX_CREDITS
//   o_draining       FSM in DRAIN
//   o_drained        one-cycle pulse when a drain completes
//   o_err_overflow   sticky: return accepted while already full
//   o_err_underflow  sticky: decrement applied while decr3 borrow was set
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | one cycle after reset release, consumes blocked
// RUN   | normal operation, consumes granted while credits remain
// DRAIN | consumes blocked until the count is back at MAX_CREDITS

// Decrement lookup: q = a - 1 (mod 8), c = borrow out when a == 0.
module macro_rom_decr3 (
   input  logic [2:0] a,
   output logic [2:0] q,
   output logic       c
);
   always_comb begin
      q = 3'd0;
      c = 1'b0;
      case (a)
         3'd0: begin q = 3'd7; c = 1'b1; end
         3'd1: q = 3'd0;
         3'd2: q = 3'd1;
         3'd3: q = 3'd2;
         3'd4: q = 3'd3;
         3'd5: q = 3'd4;
         3'd6: q = 3'd5;
         3'd7: q = 3'd6;
         default: begin q = 3'd0; c = 1'b0; end
      endcase
   end
endmodule

module macro_credit_cnt3 #(
   parameter int INIT_CREDITS = 7,
   parameter int MAX_CREDITS  = 7
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       i_consume_valid,
   output logic       o_consume_ready,
   input  logic       i_return,
   input  logic       i_drain,
   input  logic       i_err_clear,
   output logic [2:0] o_credits,
   output logic       o_empty,
   output logic       o_full,
   output logic       o_draining,
   output logic       o_drained,
   output logic       o_err_overflow,
   output logic       o_err_underflow
);
   localparam logic [2:0] INIT_C = 3'(INIT_CREDITS);
   localparam logic [2:0] MAX_C  = 3'(MAX_CREDITS);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t     state;
   logic [2:0] cnt;
   logic [2:0] decr_q;
   logic       decr_c;
   logic       fire;
   logic       ovf_set;
   logic       unf_set;

   macro_rom_decr3 u_decr (
      .a (cnt),
      .q (decr_q),
      .c (decr_c)
   );

   assign o_consume_ready = (state == ST_RUN) && (cnt != 3'd0);
   assign fire            = i_consume_valid && o_consume_ready;

   // A consume and a return in the same cycle cancel out, so neither error
   // can be raised then, even when the counter sits at the ceiling.
   assign ovf_set = !fire && i_return && !(cnt < MAX_C);
   assign unf_set = fire && !i_return && decr_c;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state           <= ST_INIT;
         cnt             <= INIT_C;
         o_drained       <= 1'b0;
         o_err_overflow  <= 1'b0;
         o_err_underflow <= 1'b0;
      end else begin
         o_drained <= 1'b0;
         case (state)
            ST_INIT: state <= ST_RUN;
            ST_RUN: begin
               if (i_drain) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (cnt == MAX_C) begin
                  state     <= ST_RUN;
                  o_drained <= 1'b1;
               end
            end
            default: state <= ST_INIT;
         endcase

         if (fire && !i_return)
            cnt <= decr_q;
         else if (!fire && i_return && (cnt < MAX_C))
            cnt <= cnt + 3'd1;

         // Set wins over clear.
         o_err_overflow  <= ovf_set || (o_err_overflow  && !i_err_clear);
         o_err_underflow <= unf_set || (o_err_underflow && !i_err_clear);
      end
   end

   assign o_credits  = cnt;
   assign o_empty    = (cnt == 3'd0);
   assign o_full     = (cnt == MAX_C);
   assign o_draining = (state == ST_DRAIN);
endmodule

// File: tb/tb_macro_credit_cnt3.sv
// Directed bench for macro_credit_cnt3 with INIT_CREDITS = MAX_CREDITS = 7.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_macro_credit_cnt3;
   logic       clk = 1'b0;
   logic       resetn;
   logic       i_consume_valid;
   logic       o_consume_ready;
   logic       i_return;
   logic       i_drain;
   logic       i_err_clear;
   logic [2:0] o_credits;
   logic       o_empty;
   logic       o_full;
   logic       o_draining;
   logic       o_drained;
   logic       o_err_overflow;
   logic       o_err_underflow;

   int errors = 0;
   int checks = 0;

   macro_credit_cnt3 #(.INIT_CREDITS(7), .MAX_CREDITS(7)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .i_consume_valid (i_consume_valid),
      .o_consume_ready (o_consume_ready),
      .i_return        (i_return),
      .i_drain         (i_drain),
      .i_err_clear     (i_err_clear),
      .o_credits       (o_credits),
      .o_empty         (o_empty),
      .o_full          (o_full),
      .o_draining      (o_draining),
      .o_drained       (o_drained),
      .o_err_overflow  (o_err_overflow),
      .o_err_underflow (o_err_underflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; i_consume_valid = 1'b0; i_return = 1'b0;
      i_drain = 1'b0; i_err_clear = 1'b0;
      step(); step();
      checks++;
      if (o_credits !== 3'd7 || o_full !== 1'b1 || o_empty !== 1'b0) begin
         errors++;
         $display("FAIL reset_cnt: credits=%0d full=%b empty=%b, want 7 1 0", o_credits, o_full, o_empty);
      end
      checks++;
      if (o_consume_ready !== 1'b0 || o_draining !== 1'b0 || o_drained !== 1'b0 ||
          o_err_overflow !== 1'b0 || o_err_underflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: rdy=%b drn=%b drd=%b ovf=%b unf=%b, want all 0",
                  o_consume_ready, o_draining, o_drained, o_err_overflow, o_err_underflow);
      end
      resetn = 1'b1;
      checks++;
      if (o_consume_ready !== 1'b0) begin
         errors++;
         $display("FAIL init_ready: ready=%b, want 0", o_consume_ready);
      end
      step();
      checks++;
      if (o_consume_ready !== 1'b1 || o_credits !== 3'd7) begin
         errors++;
         $display("FAIL run_ready: ready=%b credits=%0d, want 1 7", o_consume_ready, o_credits);
      end
   endtask

   task automatic test_consume_to_empty();
      int exp;
      i_consume_valid = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         step();
         exp = (7 - i < 0) ? 0 : 7 - i;
         checks++;
         if (o_credits !== 3'(exp)) begin
            errors++;
            $display("FAIL consume_cnt[%0d]: credits=%0d, want %0d", i, o_credits, exp);
         end
      end
      checks++;
      if (o_consume_ready !== 1'b0 || o_empty !== 1'b1 ||
          o_err_overflow !== 1'b0 || o_err_underflow !== 1'b0) begin
         errors++;
         $display("FAIL empty_state: rdy=%b empty=%b ovf=%b unf=%b, want 0 1 0 0",
                  o_consume_ready, o_empty, o_err_overflow, o_err_underflow);
      end
      i_consume_valid = 1'b0;
   endtask

   task automatic test_empty_valid_return();
      i_consume_valid = 1'b1; i_return = 1'b1;
      step();
      i_consume_valid = 1'b0; i_return = 1'b0;
      checks++;
      if (o_credits !== 3'd1 || o_consume_ready !== 1'b1) begin
         errors++;
         $display("FAIL empty_vr: credits=%0d ready=%b, want 1 1", o_credits, o_consume_ready);
      end
   endtask

   task automatic test_back_to_back();
      int fires = 0;
      i_return = 1'b1;
      step(); step();
      checks++;
      if (o_credits !== 3'd3) begin
         errors++;
         $display("FAIL b2b_setup: credits=%0d, want 3", o_credits);
      end
      i_consume_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (o_consume_ready === 1'b1) fires++;
         step();
         checks++;
         if (o_credits !== 3'd3) begin
            errors++;
            $display("FAIL b2b_cnt[%0d]: credits=%0d, want 3", i, o_credits);
         end
      end
      i_consume_valid = 1'b0; i_return = 1'b0;
      checks++;
      if (fires !== 4) begin
         errors++;
         $display("FAIL b2b_fires: fires=%0d, want 4", fires);
      end
   endtask

   task automatic test_overflow();
      i_return = 1'b1;
      for (int i = 0; i < 4; i++) step();
      i_return = 1'b0;
      checks++;
      if (o_credits !== 3'd7 || o_full !== 1'b1 || o_err_overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_setup: credits=%0d full=%b ovf=%b, want 7 1 0", o_credits, o_full, o_err_overflow);
      end
      i_return = 1'b1;
      step();
      i_return = 1'b0;
      step();
      checks++;
      if (o_credits !== 3'd7 || o_err_overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set: credits=%0d ovf=%b, want 7 1", o_credits, o_err_overflow);
      end
      i_err_clear = 1'b1; i_return = 1'b1;
      step();
      i_return = 1'b0;
      checks++;
      if (o_err_overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set_wins: ovf=%b, want 1", o_err_overflow);
      end
      step();
      i_err_clear = 1'b0;
      checks++;
      if (o_err_overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: ovf=%b, want 0", o_err_overflow);
      end
      // Full with simultaneous fire and return is net zero, not an overflow.
      i_consume_valid = 1'b1; i_return = 1'b1;
      step();
      i_consume_valid = 1'b0; i_return = 1'b0;
      checks++;
      if (o_credits !== 3'd7 || o_err_overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_netzero: credits=%0d ovf=%b, want 7 0", o_credits, o_err_overflow);
      end
   endtask

   task automatic test_drain();
      i_consume_valid = 1'b1;
      step(); step(); step();
      i_consume_valid = 1'b0;
      i_drain = 1'b1;
      step();
      i_drain = 1'b0;
      i_consume_valid = 1'b1;
      checks++;
      if (o_credits !== 3'd4 || o_draining !== 1'b1 || o_consume_ready !== 1'b0) begin
         errors++;
         $display("FAIL drain_enter: credits=%0d draining=%b ready=%b, want 4 1 0",
                  o_credits, o_draining, o_consume_ready);
      end
      i_return = 1'b1;
      for (int i = 5; i <= 7; i++) begin
         step();
         checks++;
         if (o_credits !== 3'(i) || o_drained !== 1'b0 || o_draining !== 1'b1) begin
            errors++;
            $display("FAIL drain_ret[%0d]: credits=%0d drained=%b draining=%b, want %0d 0 1",
                     i, o_credits, o_drained, o_draining, i);
         end
      end
      i_return = 1'b0;
      step();
      i_consume_valid = 1'b0;
      checks++;
      if (o_drained !== 1'b1 || o_draining !== 1'b0 || o_consume_ready !== 1'b1 || o_credits !== 3'd7) begin
         errors++;
         $display("FAIL drain_done: drained=%b draining=%b ready=%b credits=%0d, want 1 0 1 7",
                  o_drained, o_draining, o_consume_ready, o_credits);
      end
      step();
      checks++;
      if (o_drained !== 1'b0) begin
         errors++;
         $display("FAIL drain_pulse: drained=%b, want 0", o_drained);
      end
      // Entering DRAIN already full: one cycle in DRAIN, then the pulse.
      i_drain = 1'b1;
      step();
      i_drain = 1'b0;
      checks++;
      if (o_draining !== 1'b1 || o_drained !== 1'b0) begin
         errors++;
         $display("FAIL full_drain_enter: draining=%b drained=%b, want 1 0", o_draining, o_drained);
      end
      step();
      checks++;
      if (o_draining !== 1'b0 || o_drained !== 1'b1) begin
         errors++;
         $display("FAIL full_drain_done: draining=%b drained=%b, want 0 1", o_draining, o_drained);
      end
   endtask

   task automatic test_reset_mid_drain();
      i_consume_valid = 1'b1;
      step(); step();
      i_consume_valid = 1'b0;
      i_drain = 1'b1;
      step();
      i_drain = 1'b0;
      checks++;
      if (o_credits !== 3'd5 || o_draining !== 1'b1) begin
         errors++;
         $display("FAIL mid_setup: credits=%0d draining=%b, want 5 1", o_credits, o_draining);
      end
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (o_credits !== 3'd7 || o_draining !== 1'b0 || o_consume_ready !== 1'b0 || o_drained !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: credits=%0d draining=%b ready=%b drained=%b, want 7 0 0 0",
                  o_credits, o_draining, o_consume_ready, o_drained);
      end
      step();
      resetn = 1'b1;
      step();
      checks++;
      if (o_drained !== 1'b0 || o_consume_ready !== 1'b1 || o_err_underflow !== 1'b0) begin
         errors++;
         $display("FAIL mid_release: drained=%b ready=%b unf=%b, want 0 1 0",
                  o_drained, o_consume_ready, o_err_underflow);
      end
   endtask

   initial begin
      test_reset();
      test_consume_to_empty();
      test_empty_valid_return();
      test_back_to_back();
      test_overflow();
      test_drain();
      test_reset_mid_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
